// File: rtl/dffpipe_lrc.sv
// ---------------------------------------------------------------------------
// dffpipe_lrc
//   DEPTH-stage registered pipeline with a valid/ready handshake. Each stage
//   has its own valid bit. Items advance into empty stages even while the
//   output is stalled, so bubbles collapse. With CLEAR_BUBBLES=1, a stage
//   that holds no valid item has its data register cleared to zero. This
//   keeps the outputs quiet.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rstn       : synchronous reset, active low; has the highest priority
//   flush      : synchronous clear of every stage; no input is accepted
//   in_valid   : upstream has an item
//   in_ready   : this pipe accepts an item this cycle (combinational)
//   in_data    : upstream payload
//   out_valid  : valid bit of the last stage
//   out_ready  : downstream accepts the last-stage item
//   out_data   : data register of the last stage
//   occupancy  : number of valid stages (registered)
// ---------------------------------------------------------------------------
module dffpipe_lrc #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 4,
    parameter bit CLEAR_BUBBLES = 1'b1,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      occupancy
);

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0]                 occ_q,   occ_d;

    logic [DEPTH-1:0]                 stage_rdy;
    logic [DEPTH-1:0]                 up_vld;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] up_data;
    logic                             in_fire;
    logic                             out_fire;

    // A stage may load when it is empty or when everything downstream of it
    // can move. This is the unrolled form of the recurrence
    // ready[i] = !valid[i] || ready[i+1] with ready[DEPTH] = out_ready.
    // Unrolling it avoids a vector whose bits depend on its own other bits.
    always_comb begin
        stage_rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!valid_q[j]) stage_rdy[i] = 1'b1;
            end
        end
    end

    assign in_ready  = stage_rdy[0] & ~flush & rstn;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = valid_q[DEPTH-1] & out_ready;

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        up_vld     = '0;
        up_data    = '0;
        up_vld[0]  = in_fire;
        up_data[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_vld[i]  = valid_q[i-1];
            up_data[i] = data_q[i-1];
        end

        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_rdy[i]) begin
                valid_d[i] = up_vld[i];
                if (up_vld[i])          data_d[i] = up_data[i];
                else if (CLEAR_BUBBLES) data_d[i] = '0;
            end
        end

        occ_d = occ_q;
        if (in_fire && !out_fire)      occ_d = occ_q + CNT_W'(1);
        else if (!in_fire && out_fire) occ_d = occ_q - CNT_W'(1);

        // Flush wipes the data too, whatever CLEAR_BUBBLES says. A head
        // item presented with out_ready=1 this cycle has already been taken.
        if (flush) begin
            valid_d = '0;
            data_d  = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_dffpipe_lrc.sv
// ---------------------------------------------------------------------------
// tb_dffpipe_lrc
//   Directed bench for dffpipe_lrc with DEPTH=4 and DATA_WIDTH=16. It runs
//   two instances in lockstep on the same inputs. "dut" is built with
//   CLEAR_BUBBLES=1 and "dut0" with CLEAR_BUBBLES=0. Inputs change 1 time
//   unit after a rising edge, and checks follow 1 time unit later.
// ---------------------------------------------------------------------------
module tb_dffpipe_lrc;

    localparam int DW = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rstn, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready,  out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] occupancy;
    logic          in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_b;
    logic [CW-1:0] occupancy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dffpipe_lrc #(.DATA_WIDTH(DW), .DEPTH(D), .CLEAR_BUBBLES(1'b1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    dffpipe_lrc #(.DATA_WIDTH(DW), .DEPTH(D), .CLEAR_BUBBLES(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occupancy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // ---- initial reset ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_occ",       occupancy, 3'd0);
        chk("rst_out_data",  out_data,  16'h0000);
        rstn = 1'b1;
        #1;
        chk("rel_in_ready",  in_ready,  1'b1);
        tick();

        // ---- streaming: 0x0001..0x0010 on consecutive edges ----
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 16);
            in_data  = 16'(k + 1);
            #1;
            if (k < 16) chk("stream_in_ready", in_ready, 1'b1);
            if (k <= 16) chk("stream_occ", occupancy, (k < 4) ? 3'(k) : 3'd4);
            if (k >= 4) begin
                chk("stream_out_valid", out_valid, 1'b1);
                chk("stream_out_data",  out_data,  16'(k - 3));
            end else begin
                chk("stream_out_idle",  out_valid, 1'b0);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("stream_drained_v",   out_valid, 1'b0);
        chk("stream_drained_occ", occupancy, 3'd0);
        tick();

        // ---- backpressure: offer 0xA000..0xA004 with out_ready=0 ----
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'((i < 4) ? i : 4);
            #1;
            chk("bp_in_ready", in_ready, (i < 4) ? 1'b1 : 1'b0);
            if (i >= 4) chk("bp_occ_full", occupancy, 3'd4);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", in_ready,  1'b1);
        chk("bp_head_v",        out_valid, 1'b1);
        chk("bp_head_d",        out_data,  16'hA000);
        tick();
        in_valid = 1'b0;
        for (int m = 1; m <= 4; m++) begin
            #1;
            chk("bp_drain_v", out_valid, 1'b1);
            chk("bp_drain_d", out_data,  16'hA000 + 16'(m));
            tick();
        end
        chk("bp_empty_v",   out_valid, 1'b0);
        chk("bp_empty_occ", occupancy, 3'd0);

        // ---- reset with a full pipe ----
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h5550 + 16'(i);
            tick();
        end
        chk("full_occ", occupancy, 3'd4);
        rstn = 1'b0;
        #1;
        chk("rst2_in_ready_comb", in_ready, 1'b0);
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst2_out_valid", out_valid, 1'b0);
            chk("rst2_out_data",  out_data,  16'h0000);
            chk("rst2_occ",       occupancy, 3'd0);
            chk("rst2_in_ready",  in_ready,  1'b0);
        end
        rstn    = 1'b1;
        in_data = 16'h7777;
        #1;
        chk("rst2_rel_in_ready", in_ready, 1'b1);
        tick();
        chk("rst2_first_accept", occupancy, 3'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("rst2_drain_occ", occupancy, 3'd0);

        // ---- bubble collapse ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        in_valid = 1'b1; in_data = 16'h2222;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bub_valid_vec", dut.valid_q,   4'b1100);
        chk("bub_stage3",    dut.data_q[3], 16'h1111);
        chk("bub_stage2",    dut.data_q[2], 16'h2222);
        chk("bub_occ",       occupancy,     3'd2);
        chk("bub_in_ready",  in_ready,      1'b1);
        out_ready = 1'b1;
        #1;
        chk("bub_out1", out_data, 16'h1111);
        tick();
        chk("bub_out2_v", out_valid, 1'b1);
        chk("bub_out2",   out_data,  16'h2222);
        tick();
        chk("bub_done_v", out_valid, 1'b0);

        // ---- CLEAR_BUBBLES on both instances ----
        in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("cb_head_v",  out_valid,   1'b1);
        chk("cb_head_d",  out_data,    16'hBEEF);
        chk("cb0_head_d", out_data_b,  16'hBEEF);
        tick();
        chk("cb_after_v",  out_valid,   1'b0);
        chk("cb_after_d",  out_data,    16'h0000);
        chk("cb0_after_v", out_valid_b, 1'b0);
        chk("cb0_after_d", out_data_b,  16'hBEEF);
        repeat (2) tick();
        chk("cb0_hold_d",  out_data_b,  16'hBEEF);

        // ---- flush colliding with input and output transfers ----
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hC000 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("fl_pre_occ",  occupancy, 3'd3);
        chk("fl_pre_head", out_data,  16'hC001);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hC004; out_ready = 1'b1;
        #1;
        chk("fl_in_ready",  in_ready,  1'b0);
        chk("fl_out_valid", out_valid, 1'b1);
        chk("fl_out_data",  out_data,  16'hC001);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_post_v",     out_valid,    1'b0);
        chk("fl_post_occ",   occupancy,    3'd0);
        chk("fl_post_data",  dut.data_q,   64'h0);
        chk("fl_post_vvec",  dut.valid_q,  4'b0000);
        chk("fl0_post_data", dut0.data_q,  64'h0);
        chk("fl0_post_occ",  occupancy_b,  3'd0);
        repeat (3) tick();
        chk("fl_late_v",   out_valid, 1'b0);
        chk("fl_late_occ", occupancy, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
